// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern sequencer (binary count, rotate, bounce, blink)
// with a registered step pulse; a mode change reseeds the pattern and restarts the prescaler.
module led_pattern_gen #(
  parameter int N_LEDS  = 3,
  parameter int CLK_DIV = 12000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic              tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_LEDS-1:0] led_q, led_d, nxt, up_sh, dn_sh, seed;
  logic [1:0]        mode_q;
  logic              dir_q, dir_d, nxt_dir, tick_q, tick_d, chg, step;
  always_comb begin
    chg     = mode != mode_q;
    step    = en && cnt_q == CNT_MAX && !chg;
    up_sh   = led_q << 1;
    dn_sh   = led_q >> 1;
    seed    = (mode[0] ^ mode[1]) ? ONE : '0;
    nxt     = mode_q == 2'd0 ? led_q + ONE :
              mode_q == 2'd1 ? up_sh | (led_q >> (N_LEDS - 1)) :
              mode_q == 2'd2 ? (N_LEDS == 1 ? led_q : dir_q ? dn_sh : up_sh) :
                               ~led_q;
    // bounce turns around in the same step that lands on an end bit
    nxt_dir = (mode_q == 2'd2 && N_LEDS > 1) ? (dir_q ? !dn_sh[0] : up_sh[N_LEDS-1]) : dir_q;
    cnt_d   = (chg || step) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    led_d   = chg ? seed : step ? nxt : led_q;
    dir_d   = chg ? 1'b0 : step ? nxt_dir : dir_q;
    tick_d  = step;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      led_q  <= '0;
      mode_q <= 2'd0;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      mode_q <= mode;
      dir_q  <= dir_d;
      tick_q <= tick_d;
    end
  end
  assign led  = led_q;
  assign tick = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scenario tasks plus randomized traffic for led_pattern_gen (N_LEDS=4, CLK_DIV=4),
// checked against a step-counting reference model that tracks bounce position as an index.
module tb_led_pattern_gen;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] led;
  logic       tick;
  int errors = 0, checks = 0;
  int m_cnt, m_mode, m_idx, m_led;
  bit m_tick;
  int bpos[6]    = '{0, 1, 2, 3, 2, 1};
  int rot_tbl[4] = '{2, 4, 8, 1};
  int bnc_tbl[7] = '{2, 4, 8, 4, 2, 1, 2};
  int blk_tbl[3] = '{15, 0, 15};

  led_pattern_gen #(.N_LEDS(4), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_idx = 0; m_led = 0; m_tick = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_cnt = 0; m_tick = 0; m_idx = 0;
      m_led = (mode == 2'd1 || mode == 2'd2) ? 1 : 0;
    end else if (!en) m_tick = 0;
    else if (m_cnt < 3) begin m_cnt++; m_tick = 0; end
    else begin
      m_cnt = 0; m_tick = 1;
      case (m_mode)
        0: m_led = (m_led + 1) % 16;
        1: m_led = (m_led * 2) % 16 + m_led / 8;
        2: begin m_idx = (m_idx + 1) % 6; m_led = 1 << bpos[m_idx]; end
        default: m_led = 15 - m_led;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (led !== 4'd0 || tick !== 1'b0) begin errors++; $display("FAIL reset_async: led=%b tick=%b want 0000/0", led, tick); end
    repeat (2) cyc();
    checks++;
    if (led !== 4'd0 || tick !== 1'b0) begin errors++; $display("FAIL reset_hold: led=%b tick=%b want 0000/0", led, tick); end
    rst = 1'b0;
  endtask

  task automatic test_count();
    en = 1'b1; mode = 2'd0;
    for (int k = 1; k <= 68; k++) begin
      cyc();
      checks++;
      if (tick !== (k % 4 == 0) || led !== 4'((k / 4) % 16)) begin
        errors++; $display("FAIL count edge%0d: led=%b tick=%b want led=%b tick=%b", k, led, tick, 4'((k / 4) % 16), k % 4 == 0);
      end
      checks++;
      if (led !== 4'(m_led) || tick !== m_tick) begin errors++; $display("FAIL count_model edge%0d: led=%b tick=%b want %b/%b", k, led, tick, 4'(m_led), m_tick); end
    end
  endtask

  task automatic test_rotate();
    mode = 2'd1;
    cyc();
    checks++;
    if (led !== 4'b0001 || tick !== 1'b0) begin errors++; $display("FAIL rotate_seed: led=%b tick=%b want 0001/0", led, tick); end
    for (int s = 0; s < 4; s++)
      for (int c = 1; c <= 4; c++) begin
        cyc();
        checks++;
        if (led !== 4'(m_led) || tick !== m_tick || !$onehot(led)) begin errors++; $display("FAIL rotate_model: led=%b tick=%b want %b/%b", led, tick, 4'(m_led), m_tick); end
        if (c == 4) begin
          checks++;
          if (led !== 4'(rot_tbl[s]) || tick !== 1'b1) begin errors++; $display("FAIL rotate_step%0d: led=%b tick=%b want %b/1", s, led, tick, 4'(rot_tbl[s])); end
        end
      end
  endtask

  task automatic test_bounce();
    mode = 2'd2;
    cyc();
    checks++;
    if (led !== 4'b0001 || tick !== 1'b0) begin errors++; $display("FAIL bounce_seed: led=%b tick=%b want 0001/0", led, tick); end
    for (int s = 0; s < 7; s++)
      for (int c = 1; c <= 4; c++) begin
        cyc();
        checks++;
        if (led !== 4'(m_led) || tick !== m_tick || !$onehot(led)) begin errors++; $display("FAIL bounce_model: led=%b tick=%b want %b/%b", led, tick, 4'(m_led), m_tick); end
        if (c == 4) begin
          checks++;
          if (led !== 4'(bnc_tbl[s]) || tick !== 1'b1) begin errors++; $display("FAIL bounce_step%0d: led=%b tick=%b want %b/1", s, led, tick, 4'(bnc_tbl[s])); end
        end
      end
  endtask

  task automatic test_blink_freeze();
    mode = 2'd3;
    cyc();
    checks++;
    if (led !== 4'b0000 || tick !== 1'b0) begin errors++; $display("FAIL blink_seed: led=%b tick=%b want 0000/0", led, tick); end
    for (int s = 0; s < 3; s++) begin
      repeat (4) cyc();
      checks++;
      if (led !== 4'(blk_tbl[s]) || tick !== 1'b1) begin errors++; $display("FAIL blink_step%0d: led=%b tick=%b want %b/1", s, led, tick, 4'(blk_tbl[s])); end
    end
    repeat (2) cyc();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      checks++;
      if (led !== 4'b1111 || tick !== 1'b0 || led !== 4'(m_led)) begin errors++; $display("FAIL freeze%0d: led=%b tick=%b want 1111/0", c, led, tick); end
    end
    en = 1'b1;
    cyc();
    checks++;
    if (led !== 4'b1111 || tick !== 1'b0) begin errors++; $display("FAIL resume_early: led=%b tick=%b want 1111/0", led, tick); end
    cyc();
    checks++;
    if (led !== 4'b0000 || tick !== 1'b1) begin errors++; $display("FAIL resume_step: led=%b tick=%b want 0000/1", led, tick); end
  endtask

  task automatic test_mode_change_at_wrap();
    repeat (3) cyc();
    checks++;
    if (m_cnt != 3 || led !== 4'b0000) begin errors++; $display("FAIL wrap_setup: led=%b want 0000 at count 3", led); end
    mode = 2'd1;
    cyc();
    checks++;
    if (led !== 4'b0001 || tick !== 1'b0) begin errors++; $display("FAIL wrap_chg: led=%b tick=%b want 0001/0", led, tick); end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++;
      if (tick !== (c == 4) || led !== (c == 4 ? 4'b0010 : 4'b0001)) begin errors++; $display("FAIL wrap_next%0d: led=%b tick=%b want tick=%b", c, led, tick, c == 4); end
    end
  endtask

  task automatic test_async_reset();
    repeat (2) cyc();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (led !== 4'b0000 || tick !== 1'b0) begin errors++; $display("FAIL areset_now: led=%b tick=%b want 0000/0", led, tick); end
    cyc();
    #2 rst = 1'b0;
    cyc();
    checks++;
    if (led !== 4'b0001 || tick !== 1'b0) begin errors++; $display("FAIL areset_seed: led=%b tick=%b want 0001/0", led, tick); end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++;
      if (tick !== (c == 4) || led !== (c == 4 ? 4'b0010 : 4'b0001)) begin errors++; $display("FAIL areset_next%0d: led=%b tick=%b want tick=%b", c, led, tick, c == 4); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; model_reset(); #2 rst = 1'b0;
      end
      cyc();
      checks++;
      if (led !== 4'(m_led) || tick !== m_tick) begin errors++; $display("FAIL random%0d: led=%b tick=%b want %b/%b", k, led, tick, 4'(m_led), m_tick); end
      if (m_mode == 1 || m_mode == 2) begin
        checks++;
        if (!$onehot(led)) begin errors++; $display("FAIL onehot%0d: led=%b want one bit set", k, led); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_rotate();
    test_bounce();
    test_blink_freeze();
    test_mode_change_at_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
